dest_scoreboard: RTL

Destination-register scoreboard for the pipelined datapath. It consumes the destination address chosen at decode (`DEST_SELECTOR` output) together with the source addresses of each issuing instruction. It tracks in-flight writes through a fixed-latency slot pipeline and stalls issue on RAW/WAW hazards. It also emits the write-back address for the register file when each write retires.

---
 rtl/dest_scoreboard_pkg.sv | 21 ++
 rtl/dest_slot_pipe.sv | 29 ++
 rtl/dest_scoreboard.sv | 89 ++++++++
 3 files changed

// File: rtl/dest_scoreboard_pkg.sv
// Shared types for the destination-register scoreboard: address width, slot record,
// and the one-hot register decode.
package dest_scoreboard_pkg;

  localparam int unsigned ADDR_W           = 6;
  localparam int unsigned NUM_REGS         = 2 ** ADDR_W;
  localparam bit          ZERO_REG_DEFAULT = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dest_slot_pipe.sv
// Fixed-depth shift register of in-flight write slots with synchronous clear.
module dest_slot_pipe
  import dest_scoreboard_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  slot_t slot_in,
  output slot_t slot_out
);

  slot_t slot_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(Depth); k++) slot_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < int'(Depth); k++) slot_q[k] <= '0;
    end else begin
      slot_q[0] <= slot_in;
      for (int k = 1; k < int'(Depth); k++) slot_q[k] <= slot_q[k-1];
    end
  end

  assign slot_out = slot_q[Depth-1];

endmodule

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard: tracks in-flight writes, stalls issue on RAW/WAW
// hazards and presents the retiring write-back address.
module dest_scoreboard
  import dest_scoreboard_pkg::*;
#(
  parameter int unsigned LATENCY  = 3,
  parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned CntW    = $clog2(LATENCY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  input  logic                src_a_used,
  input  logic                src_b_used,
  input  logic [ADDR_W-1:0]   dest_addr,
  input  logic                dest_we,
  input  logic                flush,
  output logic                wb_valid,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic [CntW-1:0]     inflight_cnt
);

  logic [NUM_REGS-1:0] pending_q, pending_d, pend_eff;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tracked, accept, track_acc;
  slot_t               slot_in, slot_out;

  dest_slot_pipe #(
    .Depth(LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .slot_in (slot_in),
    .slot_out(slot_out)
  );

  assign wb_valid = slot_out.valid;
  assign wb_addr  = slot_out.addr;

  // A register retiring this cycle no longer blocks issue.
  assign pend_eff = pending_q & ~(wb_valid ? onehot(wb_addr) : '0);
  assign tracked  = dest_we && !(ZERO_REG && (dest_addr == '0));

  assign issue_ready = rst_n && !flush
                    && !(src_a_used && pend_eff[src_a])
                    && !(src_b_used && pend_eff[src_b])
                    && !(tracked && pend_eff[dest_addr]);

  assign accept    = issue_valid && issue_ready;
  assign track_acc = accept && tracked;

  always_comb begin
    slot_in       = '0;
    slot_in.valid = track_acc;
    slot_in.addr  = track_acc ? dest_addr : '0;
  end

  // Set after clear so a same-address retire/issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)  pending_d = pending_d & ~onehot(wb_addr);
    if (track_acc) pending_d = pending_d | onehot(dest_addr);
    if (flush)     pending_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q + CntW'(track_acc) - CntW'(wb_valid);
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending      = pending_q;
  assign inflight_cnt = cnt_q;

endmodule
